bcd_conversion_sequencer: RTL and testbench
===========================================

BCD_CONVERSION_SEQUENCER -- requirements
Module: bcd_conversion_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the binary input width; legal range 4..9 (maximum value 511 fits in three BCD digits).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a conversion; it is sampled only in IDLE.
REQ-005 binary_val  input  WIDTH  SHALL be the unsigned value to convert; it is captured in the cycle start is accepted.
REQ-006 busy  output  1  SHALL be high while a conversion is in progress (states SHIFT and DONE).
REQ-007 done  output  1  SHALL be a one-cycle pulse marking a new valid result.
REQ-008 bcd_val_2, bcd_val_1, bcd_val_0  output  4 each  SHALL be the hundreds, tens and units digits (BCD, 0..9).

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-010 IDLE with start=1 -> SHIFT; the block SHALL capture binary_val into the shift register, clear the 12-bit digit scratch and load the iteration counter with WIDTH.
REQ-011 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-012 Each SHIFT cycle SHALL perform one double-dabble step: add 3 to every scratch digit >= 5, then shift {scratch, binary} left by 1, then decrement the counter.
REQ-013 SHIFT -> DONE SHALL occur when the counter reaches 0, after exactly WIDTH SHIFT cycles.
REQ-014 In DONE, the block SHALL copy the scratch digits to the bcd_val_* outputs and assert done, with the new values visible in the same cycle that done is high; DONE -> IDLE unconditionally.
REQ-015 Latency: with start accepted at edge N, done SHALL be high during the cycle after edge N+WIDTH+1 (WIDTH+1 cycles; 9 cycles for WIDTH=8).
REQ-016 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued; binary_val changes during busy SHALL have no effect.
REQ-017 start held high continuously SHALL yield back-to-back conversions, one every WIDTH+2 cycles, each capturing binary_val in its IDLE cycle.
REQ-018 bcd_val_* SHALL hold the last result between done pulses; they SHALL never show intermediate scratch values.
REQ-019 Every output digit SHALL be in 0..9 for every legal input; the hundreds digit SHALL be at most 5 for WIDTH=9 and at most 2 for WIDTH=8.

Reset
REQ-020 When reset=1 at a clock edge, the state SHALL go to IDLE, and busy, done, the counter, the scratch and all bcd_val_* SHALL be cleared to 0.
REQ-021 Reset SHALL take priority over start in the same cycle.
REQ-022 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse; the next start SHALL be served normally.

Configuration
REQ-023 With macro BCD_BLANK_EN defined, the block SHALL add output port blank (3 bits, registered, updated together with bcd_val_*, reset to 0).
REQ-024 blank bit rules: blank[2]=1 if bcd_val_2==0; blank[1]=1 if bcd_val_2==0 and bcd_val_1==0; blank[0]=0 always, so the units digit is always shown.
REQ-025 Without BCD_BLANK_EN, the blank port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 WIDTH=8, start with binary_val=0 -> done exactly 9 cycles later; digits 0,0,0; busy high for 9 cycles.
REQ-027 Boundary sweep 9, 10, 99, 100, 255 -> results 0/0/9, 0/1/0, 0/9/9, 1/0/0, 2/5/5; exhaustive 0..255 matches a reference model.
REQ-028 start with 200, then start pulsed with 37 on the 4th busy cycle -> single done with 2/0/0; no second done.
REQ-029 Reset asserted on the 5th SHIFT cycle of a conversion of 123 -> no done; all outputs 0; the next start with 45 -> 0/4/5.
REQ-030 BCD_BLANK_EN defined: inputs 7, 42, 0, 150 -> blank = 3'b110, 3'b100, 3'b110, 3'b000; macro undefined -> port absent, elaboration succeeds.
REQ-031 WIDTH=9, input 511 -> 5/1/1 after 10 cycles; start held high -> done pulses exactly 11 cycles apart.

Source files
------------

// File: rtl/bcd_conversion_sequencer.sv
// bcd_conversion_sequencer
//   Serial binary-to-BCD converter that uses the double-dabble (shift-and-add-3) method.
//   A conversion is accepted from IDLE when start is high. It takes WIDTH SHIFT cycles and
//   then one DONE cycle. The result and a one-cycle done pulse become visible together in
//   the cycle after DONE.
//
// Parameters
//   WIDTH       binary input width, 4..9 (the result fits in three BCD digits)
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset       synchronous, active-high reset
//   start       conversion request; sampled only in IDLE
//   binary_val  unsigned value to convert; captured when start is accepted
//   busy        high while a conversion is in progress (SHIFT or DONE)
//   done        one-cycle pulse that marks a new result on bcd_val_*
//   bcd_val_2   hundreds digit
//   bcd_val_1   tens digit
//   bcd_val_0   units digit
//   blank       leading-zero blanking flags {hundreds, tens, units}. Present only when
//               the macro BCD_BLANK_EN is defined.

module bcd_conversion_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] binary_val,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd_val_2,
    output logic [3:0]       bcd_val_1,
    output logic [3:0]       bcd_val_0
`ifdef BCD_BLANK_EN
    ,
    output logic [2:0]       blank
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] shift_q;
    logic [11:0]      scratch_q;
    logic [CntW-1:0]  cnt_q;
    logic             done_q;
    logic [3:0]       bcd2_q, bcd1_q, bcd0_q;

    logic [11:0]      scratch_adj;
    logic [11:0]      scratch_step;
    logic [WIDTH-1:0] shift_step;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StShift;
            // The last step is the one that brings the counter from 1 to 0.
            StShift: if (cnt_q == CntW'(1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
    end

    // One double-dabble step: correct every digit >= 5, then shift {scratch, binary} left.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {scratch_step, shift_step} = {scratch_adj, shift_q} << 1;
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bcd2_q    <= 4'd0;
            bcd1_q    <= 4'd0;
            bcd0_q    <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q   <= binary_val;
                        scratch_q <= '0;
                        cnt_q     <= CntW'(WIDTH);
                    end
                end
                StShift: begin
                    shift_q   <= shift_step;
                    scratch_q <= scratch_step;
                    cnt_q     <= cnt_q - CntW'(1);
                end
                StDone: begin
                    // The outputs change only here, so scratch values never leak out.
                    bcd2_q <= scratch_q[11:8];
                    bcd1_q <= scratch_q[7:4];
                    bcd0_q <= scratch_q[3:0];
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done      = done_q;
    assign bcd_val_2 = bcd2_q;
    assign bcd_val_1 = bcd1_q;
    assign bcd_val_0 = bcd0_q;

`ifdef BCD_BLANK_EN
    logic [2:0] blank_q;

    // Blanking flags are registered in step with the digits. The units digit is never
    // blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= 3'b000;
        end else if (state_q == StDone) begin
            blank_q[2] <= (scratch_q[11:8] == 4'd0);
            blank_q[1] <= (scratch_q[11:8] == 4'd0) && (scratch_q[7:4] == 4'd0);
            blank_q[0] <= 1'b0;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_conversion_sequencer.sv
module tb_bcd_conversion_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset  = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] val8   = 8'd0;
    logic       start9 = 1'b0;
    logic [8:0] val9   = 9'd0;
    logic       busy8, done8, busy9, done9;
    logic [3:0] d8_2, d8_1, d8_0, d9_2, d9_1, d9_0;
`ifdef BCD_BLANK_EN
    logic [2:0] blank8, blank9;
`endif

    bcd_conversion_sequencer #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start8),
        .binary_val (val8),
        .busy       (busy8),
        .done       (done8),
        .bcd_val_2  (d8_2),
        .bcd_val_1  (d8_1),
        .bcd_val_0  (d8_0)
`ifdef BCD_BLANK_EN
        ,
        .blank      (blank8)
`endif
    );

    bcd_conversion_sequencer #(.WIDTH(9)) dut9 (
        .clk        (clk),
        .reset      (reset),
        .start      (start9),
        .binary_val (val9),
        .busy       (busy9),
        .done       (done9),
        .bcd_val_2  (d9_2),
        .bcd_val_1  (d9_1),
        .bcd_val_0  (d9_0)
`ifdef BCD_BLANK_EN
        ,
        .blank      (blank9)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Index 0 is the WIDTH=8 instance and index 1 is the WIDTH=9 instance.
    // A conversion occupies WIDTH+1 busy cycles. At the end, the result (the decimal
    // digits of the captured value) appears together with a done pulse.
    int       rem [2];
    int       cap [2];
    int       ev  [2];
    logic     ed  [2];
    logic [2:0] eb [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic s;
            int   bv;
            s  = (k == 0) ? start8 : start9;
            bv = (k == 0) ? int'(val8) : int'(val9);
            if (reset) begin
                rem[k] = 0; ed[k] = 1'b0; ev[k] = 0; eb[k] = 3'b000;
            end else if (rem[k] > 0) begin
                rem[k] = rem[k] - 1;
                ed[k]  = (rem[k] == 0);
                if (ed[k]) begin
                    ev[k] = cap[k];
                    eb[k] = {cap[k] < 100, cap[k] < 10, 1'b0};
                end
            end else begin
                ed[k] = 1'b0;
                if (s) begin
                    rem[k] = 8 + k + 1;
                    cap[k] = bv;
                end
            end
        end
    end

    // Compare on every cycle once the first reset is done
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", int'(busy8), int'(rem[0] > 0));
            check("done8", int'(done8), int'(ed[0]));
            check("hund8", int'(d8_2), ev[0] / 100);
            check("tens8", int'(d8_1), (ev[0] / 10) % 10);
            check("unit8", int'(d8_0), ev[0] % 10);
            check("busy9", int'(busy9), int'(rem[1] > 0));
            check("done9", int'(done9), int'(ed[1]));
            check("hund9", int'(d9_2), ev[1] / 100);
            check("tens9", int'(d9_1), (ev[1] / 10) % 10);
            check("unit9", int'(d9_0), ev[1] % 10);
            check("hund8_max", int'(d8_2 <= 4'd2), 1);
            check("hund9_max", int'(d9_2 <= 4'd5), 1);
`ifdef BCD_BLANK_EN
            check("blank8", int'(blank8), int'(eb[0]));
            check("blank9", int'(blank9), int'(eb[1]));
`endif
        end
    end

    // Pulse start for one cycle, then wait (with a bound) for done. lat counts cycles
    // from the accepting edge to done, and nbusy counts busy cycles before done.
    task automatic convert(input int k, input int val, output int lat, output int nbusy);
        if (k == 0) begin start8 = 1'b1; val8 = val[7:0]; end
        else        begin start9 = 1'b1; val9 = val[8:0]; end
        @(negedge clk);
        start8 = 1'b0;
        start9 = 1'b0;
        lat = 0;
        nbusy = 0;
        while (((k == 0) ? done8 : done9) == 1'b0 && lat < 40) begin
            if ((k == 0) ? busy8 : busy9) nbusy++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", int'((k == 0) ? done8 : done9), 1);
    endtask

    task automatic digits8(input string name, input int h, input int t, input int u);
        check({name, "_h"}, int'(d8_2), h);
        check({name, "_t"}, int'(d8_1), t);
        check({name, "_u"}, int'(d8_0), u);
    endtask

    initial begin
        int lat, nb, ndone, last, npulse;
        int sweep_in [5] = '{9, 10, 99, 100, 255};
        int sweep_h  [5] = '{0, 0, 0, 1, 2};
        int sweep_t  [5] = '{0, 1, 9, 0, 5};
        int sweep_u  [5] = '{9, 0, 9, 0, 5};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);
        digits8("rst", 0, 0, 0);

        // Zero input: latency and busy length
        convert(0, 0, lat, nb);
        check("lat8", lat, 9);
        check("busylen8", nb, 9);
        digits8("zero", 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            convert(0, sweep_in[i], lat, nb);
            digits8($sformatf("sweep%0d", sweep_in[i]), sweep_h[i], sweep_t[i], sweep_u[i]);
        end

`ifdef BCD_BLANK_EN
        convert(0, 7, lat, nb);   check("blank7", int'(blank8), 6);
        convert(0, 42, lat, nb);  check("blank42", int'(blank8), 4);
        convert(0, 0, lat, nb);   check("blank0", int'(blank8), 6);
        convert(0, 150, lat, nb); check("blank150", int'(blank8), 0);
`endif

        // Exhaustive sweep over every 8-bit value. The model checks each result.
        for (int v = 0; v < 256; v++) convert(0, v, lat, nb);

        // A start while busy is ignored
        start8 = 1'b1; val8 = 8'd200;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        start8 = 1'b1; val8 = 8'd37;
        @(negedge clk);
        start8 = 1'b0; val8 = 8'd0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done8) begin
                ndone++;
                digits8("ignore", 2, 0, 0);
            end
            @(negedge clk);
        end
        check("ignore_ndone", ndone, 1);

        // Reset in the 5th SHIFT cycle aborts the conversion
        start8 = 1'b1; val8 = 8'd123;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(busy8), 0);
        check("abort_done", int'(done8), 0);
        digits8("abort", 0, 0, 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        check("abort_ndone", ndone, 0);
        convert(0, 45, lat, nb);
        digits8("after_abort", 0, 4, 5);

        // WIDTH=9 maximum value
        convert(1, 511, lat, nb);
        check("lat9", lat, 10);
        check("busylen9", nb, 10);
        check("max9_h", int'(d9_2), 5);
        check("max9_t", int'(d9_1), 1);
        check("max9_u", int'(d9_0), 1);

        // Start held high: back-to-back conversions on both instances
        start9 = 1'b1;
        start8 = 1'b1;
        last = -1;
        npulse = 0;
        for (int i = 0; i < 70; i++) begin
            val9 = 9'($urandom_range(511, 0));
            val8 = 8'($urandom_range(255, 0));
            @(negedge clk);
            if (done9) begin
                if (last >= 0) check("spacing9", i - last, 11);
                last = i;
                npulse++;
            end
        end
        check("pulses9", int'(npulse >= 5), 1);
        start9 = 1'b0;
        start8 = 1'b0;
        repeat (15) @(negedge clk);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            start8 = ($urandom_range(2, 0) == 0);
            val8   = 8'($urandom_range(255, 0));
            start9 = ($urandom_range(2, 0) == 0);
            val9   = 9'($urandom_range(511, 0));
            reset  = ($urandom_range(59, 0) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        start8 = 1'b0;
        start9 = 1'b0;
        repeat (15) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
